// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: FSM states,
// port ownership and access-size encodings.
package mem_ctrl_pkg;

    localparam int REG_W      = 32;
    localparam int RAM_AW_DEF = 17;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the fetch and data ports onto one byte-wide synchronous RAM,
// splitting each access into byte transactions and reassembling loads.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [REG_W-1:0]  if_addr,
    output logic              if_ack,
    output logic [REG_W-1:0]  if_data,
    output logic              if_stall,
    input  logic              mem_ce,
    input  logic              mem_we,
    input  logic [REG_W-1:0]  mem_addr,
    input  logic [3:0]        mem_sel,
    input  logic [REG_W-1:0]  mem_wdata,
    output logic              mem_ack,
    output logic [REG_W-1:0]  mem_rdata,
    output logic              mem_stall,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    logic [1:0]        state;
    logic              owner;
    logic              we;
    logic [RAM_AW-1:0] base;
    logic [REG_W-1:0]  wdata;
    logic [REG_W-1:0]  data;
    logic [2:0]        n;
    logic [2:0]        i;

    logic [2:0]        i_nx;
    logic [1:0]        cap_idx;
    logic [REG_W-1:0]  data_cap;
    logic              unused_hi;

    function automatic logic [2:0] sel_count(input logic [3:0] sel);
        case (sel)
            SEL_BYTE: return 3'd1;
            SEL_HALF: return 3'd2;
            SEL_WORD: return 3'd4;
            default:  return 3'd4;
        endcase
    endfunction

    // Addresses wrap inside the RAM, so only the low RAM_AW bits matter.
    assign unused_hi = ^{mem_addr[REG_W-1:RAM_AW], if_addr[REG_W-1:RAM_AW]};

    assign i_nx    = i + 3'd1;
    assign cap_idx = 2'(i - 3'd1);

    // ram_din carries byte (i-1) because the RAM answers one cycle late.
    always_comb begin
        data_cap = data;
        if (i != 3'd0)
            data_cap[{cap_idx, 3'b000} +: 8] = ram_din;
    end

    assign mem_ack   = (state == ST_ACK) && (owner == OWNER_MEM);
    assign if_ack    = (state == ST_ACK) && (owner == OWNER_IF) && if_req;
    assign mem_stall = mem_ce & ~mem_ack;
    assign if_stall  = if_req & ~if_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWNER_IF;
            we        <= 1'b0;
            base      <= '0;
            wdata     <= '0;
            data      <= '0;
            n         <= '0;
            i         <= '0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
            if_data   <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Byte 0 is issued on the sampling edge so it appears in the first RUN cycle.
                    i    <= '0;
                    data <= '0;
                    if (mem_ce) begin
                        owner    <= OWNER_MEM;
                        we       <= mem_we;
                        base     <= mem_addr[RAM_AW-1:0];
                        wdata    <= mem_wdata;
                        n        <= sel_count(mem_sel);
                        ram_addr <= mem_addr[RAM_AW-1:0];
                        ram_wr   <= mem_we;
                        ram_dout <= mem_wdata[7:0];
                        state    <= ST_RUN;
                    end else if (if_req) begin
                        owner    <= OWNER_IF;
                        we       <= 1'b0;
                        base     <= if_addr[RAM_AW-1:0];
                        wdata    <= '0;
                        n        <= 3'd4;
                        ram_addr <= if_addr[RAM_AW-1:0];
                        ram_wr   <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    i <= i_nx;
                    if (!we)
                        data <= data_cap;
                    if (i_nx < n) begin
                        ram_addr <= base + RAM_AW'(i_nx);
                        ram_wr   <= we;
                        ram_dout <= wdata[{i_nx[1:0], 3'b000} +: 8];
                    end else begin
                        ram_wr <= 1'b0;
                    end
                    if (we && i_nx == n) begin
                        state <= ST_ACK;
                    end else if (!we && i == n) begin
                        state <= ST_ACK;
                        if (owner == OWNER_MEM)
                            mem_rdata <= data_cap;
                        else
                            if_data <= data_cap;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, transaction-level reference model with
// a per-cycle compare process, and directed tests with literal expectations.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ack, if_stall;
    logic [31:0] if_addr, if_data;
    logic        mem_ce, mem_we, mem_ack, mem_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_sel;
    logic [16:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout, ram_din;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.RAM_AW(17)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data), .if_stall(if_stall),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    // Synchronous byte RAM, plus a preload port used only while the DUT is idle.
    bit   [7:0]  ram [0:(1<<17)-1];
    logic        pl_en = 1'b0;
    logic [16:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always @(posedge clk) begin
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (ram_wr)
            ram[ram_addr] <= ram_dout;
        ram_din <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: one transaction at a time, timing from the latency rules.
    bit   [7:0]  shadow [0:(1<<17)-1];
    int          e = 0, t0 = 0, lat_m = 0, k = 0, m_n = 0;
    bit          busy = 0, idle = 0, m_mem = 0, m_we = 0, chk_en = 0;
    logic [31:0] m_base = '0, m_wd = '0, m_data = '0;
    bit          exp_wr = 0, exp_addr_vld = 0, exp_mem_ack = 0, exp_ack_if = 0;
    logic [16:0] exp_addr = '0;
    logic [7:0]  exp_dout = '0;
    logic [31:0] exp_mem_rdata = '0, exp_if_data = '0;

    initial begin
        forever begin
            @(posedge clk);
            e++;
            if (exp_wr) shadow[exp_addr] = exp_dout;
            if (pl_en) shadow[pl_addr] = pl_data;
            if (rst) begin
                busy = 0; idle = 1; chk_en = 1;
                exp_wr = 0; exp_addr_vld = 0; exp_mem_ack = 0; exp_ack_if = 0;
                exp_mem_rdata = '0; exp_if_data = '0;
            end else begin
                if (busy && e == t0 + lat_m) begin
                    busy = 0; idle = 1;
                end else if (idle && (mem_ce || if_req)) begin
                    busy = 1; idle = 0; t0 = e;
                    if (mem_ce) begin
                        m_mem = 1; m_we = mem_we; m_base = mem_addr; m_wd = mem_wdata;
                        m_n = (mem_sel == 4'b0001) ? 1 : (mem_sel == 4'b0011) ? 2 : 4;
                    end else begin
                        m_mem = 0; m_we = 0; m_base = if_addr; m_wd = '0; m_n = 4;
                    end
                    lat_m = m_we ? m_n + 1 : m_n + 2;
                    m_data = '0;
                    for (int j = 0; j < m_n; j++) m_data[8*j +: 8] = shadow[17'(m_base + j)];
                end
                k = e - t0;
                exp_addr_vld = busy && k < m_n;
                exp_wr = exp_addr_vld && m_we;
                if (exp_addr_vld) begin
                    exp_addr = 17'(m_base + k);
                    exp_dout = m_wd[8*k +: 8];
                end
                exp_mem_ack = busy && k == lat_m - 1 && m_mem;
                exp_ack_if  = busy && k == lat_m - 1 && !m_mem;
                if (busy && k == lat_m - 1 && !m_we) begin
                    if (m_mem) exp_mem_rdata = m_data;
                    else       exp_if_data = m_data;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("ram_wr", ram_wr, exp_wr);
                if (exp_addr_vld) chk("ram_addr", ram_addr, exp_addr);
                if (exp_wr) chk("ram_dout", ram_dout, exp_dout);
                chk("mem_ack", mem_ack, exp_mem_ack);
                chk("if_ack", if_ack, exp_ack_if && if_req);
                chk("mem_stall", mem_stall, mem_ce && !exp_mem_ack);
                chk("if_stall", if_stall, if_req && !(exp_ack_if && if_req));
                chk("mem_rdata", mem_rdata, exp_mem_rdata);
                chk("if_data", if_data, exp_if_data);
            end
        end
    end

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Counts negedges from the caller's point until the ack is seen; c0 is the offset already elapsed.
    task automatic wait_ack(input string nm, input bit is_mem, input int c0, output int lat);
        bit seen = 0;
        lat = c0;
        for (int j = 0; j < 40 && !seen; j++) begin
            @(negedge clk);
            lat++;
            if (is_mem ? mem_ack : if_ack) seen = 1;
        end
        if (!seen) chk({nm, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic run_mem(input string nm, input bit we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                           input bit ck_rd, input logic [31:0] exp_rd);
        int lat;
        @(posedge clk); #1;
        mem_ce = 1'b1; mem_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wd;
        @(posedge clk);
        wait_ack(nm, 1'b1, 0, lat);
        chk({nm, "_lat"}, lat, exp_lat);
        if (ck_rd) chk({nm, "_rdata"}, mem_rdata, exp_rd);
        @(posedge clk); #1;
        mem_ce = 1'b0;
    endtask

    initial begin
        int lat, lat2;
        rst = 1'b1; if_req = 0; if_addr = '0; mem_ce = 0; mem_we = 0;
        mem_addr = '0; mem_sel = '0; mem_wdata = '0;
        poke(17'h1000, 8'h13); poke(17'h1001, 8'h05); poke(17'h1002, 8'h10); poke(17'h1003, 8'h00);
        poke(17'h40, 8'h44); poke(17'h41, 8'h33); poke(17'h42, 8'h22); poke(17'h43, 8'h11);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ram_wr", ram_wr, 0);
        chk("reset_ram_addr", ram_addr, 0);
        chk("reset_mem_rdata", mem_rdata, 0);
        chk("reset_if_data", if_data, 0);

        run_mem("sb", 1'b1, 4'b0001, 32'h20, 32'hAABBCCDD, 2, 1'b0, '0);
        chk("sb_byte", ram[17'h20], 8'hDD);
        chk("sb_next_untouched", ram[17'h21], 8'h00);

        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h1000;
        @(posedge clk);
        wait_ack("fetch", 1'b0, 0, lat);
        chk("fetch_lat", lat, 6);
        chk("fetch_data", if_data, 32'h00100513);
        @(posedge clk); #1;
        if_req = 1'b0;

        @(posedge clk); #1;
        mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'b1111; mem_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h0;
        @(posedge clk);
        wait_ack("simul_mem", 1'b1, 0, lat);
        chk("simul_mem_lat", lat, 6);
        chk("simul_mem_rdata", mem_rdata, 32'h11223344);
        @(posedge clk); #1;
        mem_ce = 1'b0;
        wait_ack("simul_if", 1'b0, lat, lat2);
        chk("simul_if_lat", lat2, 13);
        @(posedge clk); #1;
        if_req = 1'b0;

        run_mem("sw", 1'b1, 4'b1111, 32'h200, 32'hDEADBEEF, 5, 1'b0, '0);
        run_mem("lw", 1'b0, 4'b1111, 32'h200, '0, 6, 1'b1, 32'hDEADBEEF);
        run_mem("lb", 1'b0, 4'b0001, 32'h201, '0, 3, 1'b1, 32'h000000BE);
        run_mem("sh", 1'b1, 4'b0011, 32'h204, 32'h12345678, 3, 1'b0, '0);
        run_mem("lh", 1'b0, 4'b0011, 32'h204, '0, 4, 1'b1, 32'h00005678);
        run_mem("lw_odd_sel", 1'b0, 4'b0101, 32'h200, '0, 6, 1'b1, 32'hDEADBEEF);

        poke(17'h1FFFF, 8'h80); poke(17'h0, 8'hFF);
        @(posedge clk); #1;
        mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'b0011; mem_addr = 32'h1FFFF;
        @(posedge clk);
        @(negedge clk);
        chk("wrap_addr0", ram_addr, 17'h1FFFF);
        @(negedge clk);
        chk("wrap_addr1", ram_addr, 17'h00000);
        wait_ack("wrap", 1'b1, 2, lat);
        chk("wrap_lat", lat, 4);
        chk("wrap_rdata", mem_rdata, 32'h0000FF80);
        @(posedge clk); #1;
        mem_ce = 1'b0;

        @(posedge clk); #1;
        mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b1111; mem_addr = 32'h300; mem_wdata = 32'h44332211;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; mem_ce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ram_wr", ram_wr, 0);
        chk("rst_mid_ack", mem_ack, 0);
        chk("rst_mid_b0", ram[17'h300], 8'h11);
        chk("rst_mid_b1", ram[17'h301], 8'h22);
        chk("rst_mid_b2", ram[17'h302], 8'h00);
        run_mem("sb_after_rst", 1'b1, 4'b0001, 32'h310, 32'h0000005A, 2, 1'b0, '0);
        chk("sb_after_rst_byte", ram[17'h310], 8'h5A);

        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h1000;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        if_req = 1'b0;
        mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0001; mem_addr = 32'h24; mem_wdata = 32'h00000077;
        wait_ack("flush", 1'b1, 2, lat);
        chk("flush_mem_lat", lat, 9);
        @(posedge clk); #1;
        mem_ce = 1'b0;
        @(negedge clk);
        chk("flush_sb_byte", ram[17'h24], 8'h77);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the CPU pipeline and a single byte-wide synchronous RAM.
- Arbitrates the instruction-fetch (IF) port and the data (MEM stage) port.
- Serialises each 8/16/32-bit access into 1/2/4 byte transactions.
- Returns assembled little-endian data with a one-cycle ack pulse; the pipeline stalls on the stall outputs.

Parameters:
- RAM_AW, 17, RAM address width; request addresses are truncated to RAM_AW bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch address
- if_ack  out  1  fetch complete, one-cycle pulse
- if_data  out  32  fetched word, valid with if_ack
- if_stall  out  1  if_req & ~if_ack
- mem_ce  in  1  data request, held until mem_ack
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  data address
- mem_sel  in  4  0001 = byte, 0011 = half, otherwise word
- mem_wdata  in  32  store data; low bytes used
- mem_ack  out  1  data access complete, one-cycle pulse
- mem_rdata  out  32  raw load bytes, zero-filled above size; sign extension is done by the MEM stage
- mem_stall  out  1  mem_ce & ~mem_ack
- ram_addr  out  RAM_AW  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  byte to RAM
- ram_din  in  8  byte from RAM, valid the cycle after its address is driven

Behaviour:
- Reset: rst is synchronous and active-high. On the reset edge: state=IDLE; if_ack, mem_ack, ram_wr = 0; ram_addr, ram_dout, if_data, mem_rdata = 0; counters = 0.
- States: IDLE, RUN, ACK.
- IDLE:
  - mem_ce=1: latch mem_addr, mem_we, byte count n (from mem_sel) and mem_wdata; owner=MEM; go to RUN.
  - else if_req=1: latch if_addr, n=4, we=0; owner=IF; go to RUN.
  - MEM has priority on a simultaneous request (older instruction).
  - No RAM activity in IDLE.
- RUN, with issue counter i starting at 0:
  - Each cycle with i<n: ram_addr = (base+i)[RAM_AW-1:0]; for a store, ram_wr=1 and ram_dout = wdata[8i+7:8i]; then i++.
  - Load capture: in each cycle with 1≤i≤n, ram_din is stored to byte (i-1) of the data register.
  - Store: after the cycle with i=n-1, go to ACK.
  - Load: after the capture cycle with i=n, go to ACK. ram_wr=0 in that cycle.
- ACK (one cycle):
  - Owner MEM: mem_ack=1.
  - Owner IF: if_ack=1 only if if_req is still 1. A withdrawn fetch (flush) is dropped silently.
  - The data outputs hold the assembled value, then the block returns to IDLE.
  - Requests are not sampled in ACK; the next arbitration happens in IDLE, so the pipeline can change its request on the ack edge.
- Latency, counted from the IDLE sampling edge T:
  - LW / fetch: ack at T+6.
  - LH: ack at T+4.
  - LB: ack at T+3.
  - SW: ack at T+5.
  - SH: ack at T+3.
  - SB: ack at T+2.
- No preemption: a started transaction always completes. IF waits behind MEM and vice versa.
- Address wrap: base+i is computed in 32 bits, then truncated. A half access at RAM_AW'h1FFFF accesses byte 0x1FFFF, then 0x00000.
- Reset mid-transaction: the block aborts on the reset edge with ram_wr=0 from that cycle and no ack. Bytes already written stay written.
- if_data and mem_rdata hold their last value outside ACK.

Decomposition:
- defines.v additions:
  - state encodings (IDLE/RUN/ACK)
  - owner encoding (OwnerIf/OwnerMem)
  - `RamAddrBus
  - sel encodings (SelByte=4'b0001, SelHalf=4'b0011, SelWord=4'b1111)
- The existing `RegBus, `WriteEnable and `ChipEnable are reused.
- No sub-module: the sel→count decode is a local function; arbitration and serialisation share one FSM.

Test Plan:
- Fetch: if_req=1, if_addr=0x1000, RAM[0x1000..3]=13,05,10,00 → four reads at 0x1000..0x1003; if_ack at T+6 with if_data=0x00100513; if_stall=1 until then.
- SB: mem_ce=1, mem_we=1, sel=0001, addr=0x20, wdata=0xAABBCCDD → exactly one ram_wr with ram_addr=0x20, ram_dout=0xDD; mem_ack at T+2.
- Simultaneous requests: MEM LW at 0x40 (RAM=0x11223344 little-endian) and if_req at 0x0 → mem_ack at T+6 with mem_rdata=0x11223344; fetch sampled at T+7; if_ack at T+13.
- LH at 0x1FFFF with RAM[0x1FFFF]=0x80, RAM[0x0]=0xFF → ram_addr sequence 0x1FFFF, 0x00000; mem_rdata=0x0000FF80; mem_ack at T+4.
- Reset mid-SW: assert rst after two bytes are written → ram_wr=0 from that cycle, state IDLE, no mem_ack; a new SB then completes normally.
- Fetch flush: drop if_req during RUN → no if_ack pulse; a subsequent mem_ce is served from IDLE the cycle after ACK.
